// File: rtl/mod_count_sched.sv
// mod_count_sched: modulo-M up-counter run under a three-state controller
// (IDLE/RUN/DONE) with an optional wrap budget and a two-requester,
// round-robin arbitrated load port. All outputs are registered.
module mod_count_sched #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WRAPW-1:0] nwraps,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] ld0,
    input  logic [WIDTH-1:0] ld1,
    output logic [1:0]       ack,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WRAPW-1:0] n_q, n_d;
    logic [WRAPW-1:0] wcnt_q, wcnt_d;
    logic             ptr_q, ptr_d;      // requester favoured on contention
    logic [1:0]       ack_q, ack_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [1:0]       grant;
    logic [WIDTH-1:0] ld_win;
    logic [WRAPW-1:0] wcnt_inc;
    logic             wrap_hit;
    logic             finish;

    // Arbitration and wrap detection shared by next-state and output logic
    always_comb begin
        grant = '0;
        if (state_q != S_DONE && !stop) begin
            if (req == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
            else              grant = req;
        end
        ptr_d = ptr_q;
        if (grant[0])      ptr_d = 1'b1;
        else if (grant[1]) ptr_d = 1'b0;
        ld_win   = grant[1] ? ld1 : ld0;
        // a granted load suppresses the wrap entirely
        wrap_hit = (state_q == S_RUN) && !stop && (grant == '0) && (q_q >= m_q);
        wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + WRAPW'(1);
        finish   = wrap_hit && (n_q != '0) && (wcnt_inc == n_q);
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start && !stop) state_d = S_RUN;
            S_RUN: begin
                if (stop)        state_d = S_IDLE;
                else if (finish) state_d = S_DONE;
            end
            S_DONE: begin
                if (stop)       state_d = S_IDLE;
                else if (start) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        q_d    = q_q;
        m_d    = m_q;
        n_d    = n_q;
        wcnt_d = wcnt_q;
        wrap_d = 1'b0;
        ack_d  = grant;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    m_d    = modulus;
                    n_d    = nwraps;
                    wcnt_d = '0;
                    q_d    = '0;
                end
                // a load granted on the start cycle wins over the clear
                if (grant != '0) q_d = ld_win;
            end
            S_RUN: begin
                if (!stop) begin
                    if (grant != '0) begin
                        q_d = ld_win;
                    end else if (wrap_hit) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                        wcnt_d = wcnt_inc;
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                if (start && !stop) begin
                    m_d    = modulus;
                    n_d    = nwraps;
                    wcnt_d = '0;
                    q_d    = '0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            m_q    <= '0;
            n_q    <= '0;
            wcnt_q <= '0;
            ptr_q  <= 1'b0;
            ack_q  <= '0;
            wrap_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            m_q    <= m_d;
            n_q    <= n_d;
            wcnt_q <= wcnt_d;
            ptr_q  <= ptr_d;
            ack_q  <= ack_d;
            wrap_q <= wrap_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign Q    = q_q;
    assign ack  = ack_q;
    assign busy = busy_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_mod_count_sched.sv
// Testbench for mod_count_sched: directed vectors with hand-computed
// expected outputs, queued by the stimulus and checked by a monitor.
module tb_mod_count_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop;
    logic [3:0] modulus;
    logic [7:0] nwraps;
    logic [1:0] req;
    logic [3:0] ld0, ld1;
    logic [1:0] ack;
    logic [3:0] Q;
    logic       busy, wrap, done;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        string      nm;
        logic [8:0] v;   // {Q, ack, busy, wrap, done}
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mod_count_sched #(.WIDTH(4), .WRAPW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .modulus(modulus), .nwraps(nwraps), .req(req),
        .ld0(ld0), .ld1(ld1), .ack(ack), .Q(Q),
        .busy(busy), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got Q=%0d ack=%b busy=%b wrap=%b done=%b, want Q=%0d ack=%b busy=%b wrap=%b done=%b",
                     nm, got[8:5], got[4:3], got[2], got[1], got[0],
                     want[8:5], want[4:3], want[2], want[1], want[0]);
        end
    endtask

    // Monitor: every sampled cycle is compared against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.nm, {Q, ack, busy, wrap, done}, mon_e.v);
        end
    end

    task automatic expect_v(input string nm, input logic [3:0] eq, input logic [1:0] ea,
                            input logic eb, input logic ew, input logic ed);
        exp_t e;
        e.nm = nm;
        e.v  = {eq, ea, eb, ew, ed};
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic cyc(input logic s, input logic p, input logic [1:0] r,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] eq, input logic [1:0] ea,
                       input logic eb, input logic ew, input logic ed, input string nm);
        start = s; stop = p; req = r; ld0 = a0; ld1 = a1;
        expect_v(nm, eq, ea, eb, ew, ed);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 0; stop = 0; req = 0; ld0 = 0; ld1 = 0;
        modulus = 0; nwraps = 0;
        expect_v("reset", 4'd0, 2'b00, 0, 0, 0);
        #12;
        rst = 1'b0;

        // Count 0..10 twice with N=2, then DONE
        modulus = 4'd10; nwraps = 8'd2;
        cyc(1, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 0, 0, "start_m10_n2");
        for (int unsigned k = 0; k < 2; k++) begin
            for (int i = 1; i <= 10; i++)
                cyc(0, 0, 2'b00, 0, 0, 4'(i), 2'b00, 1, 0, 0, "count");
            if (k == 0) cyc(0, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 1, 0, "wrap1");
            else        cyc(0, 0, 2'b00, 0, 0, 4'd0, 2'b00, 0, 1, 1, "wrap2_done");
        end
        cyc(0, 0, 2'b00, 0, 0, 4'd0, 2'b00, 0, 0, 1, "done_hold");
        cyc(0, 0, 2'b01, 4'd5, 0, 4'd0, 2'b00, 0, 0, 1, "done_req_ignored");
        cyc(0, 1, 2'b00, 0, 0, 4'd0, 2'b00, 0, 0, 0, "done_stop_idle");

        // Contention from reset pointer: requester 0 first, then alternate
        nwraps = 8'd0;
        cyc(1, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 0, 0, "start_m10_n0");
        cyc(0, 0, 2'b11, 4'd2, 4'd5, 4'd2, 2'b01, 1, 0, 0, "rr0");
        cyc(0, 0, 2'b11, 4'd2, 4'd5, 4'd5, 2'b10, 1, 0, 0, "rr1");
        cyc(0, 0, 2'b11, 4'd2, 4'd5, 4'd2, 2'b01, 1, 0, 0, "rr2");
        cyc(0, 0, 2'b11, 4'd2, 4'd5, 4'd5, 2'b10, 1, 0, 0, "rr3");
        cyc(0, 0, 2'b00, 0, 0, 4'd6, 2'b00, 1, 0, 0, "rr_after");
        cyc(0, 1, 2'b00, 0, 0, 4'd6, 2'b00, 0, 0, 0, "run_stop_hold");

        // Single load of 7 at Q=3
        cyc(1, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 0, 0, "restart");
        for (int i = 1; i <= 3; i++)
            cyc(0, 0, 2'b00, 0, 0, 4'(i), 2'b00, 1, 0, 0, "pre_load");
        cyc(0, 0, 2'b01, 4'd7, 0, 4'd7, 2'b01, 1, 0, 0, "load7");
        cyc(0, 0, 2'b00, 0, 0, 4'd8, 2'b00, 1, 0, 0, "post8");
        cyc(0, 0, 2'b00, 0, 0, 4'd9, 2'b00, 1, 0, 0, "post9");
        cyc(0, 0, 2'b00, 0, 0, 4'd10, 2'b00, 1, 0, 0, "post10");
        cyc(0, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 1, 0, "post_wrap");
        cyc(0, 0, 2'b00, 0, 0, 4'd1, 2'b00, 1, 0, 0, "post1");

        // Load above M wraps on the following cycle
        cyc(0, 0, 2'b10, 0, 4'd14, 4'd14, 2'b10, 1, 0, 0, "load14");
        cyc(0, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 1, 0, "wrap_from14");
        cyc(0, 0, 2'b00, 0, 0, 4'd1, 2'b00, 1, 0, 0, "after14");

        // Stop beats load; stop beats start in IDLE
        cyc(0, 1, 2'b01, 4'd9, 0, 4'd1, 2'b00, 0, 0, 0, "stop_vs_load");
        cyc(0, 0, 2'b00, 0, 0, 4'd1, 2'b00, 0, 0, 0, "idle_hold");
        cyc(1, 1, 2'b00, 0, 0, 4'd1, 2'b00, 0, 0, 0, "stop_vs_start");

        // M=0, N=0: wrap every cycle, wrap count saturates without ending the run
        modulus = 4'd0;
        cyc(1, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 0, 0, "start_m0");
        for (int i = 0; i < 300; i++)
            cyc(0, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 1, 0, "m0_wrap");
        cyc(0, 1, 2'b00, 0, 0, 4'd0, 2'b00, 0, 0, 0, "m0_stop");

        // Load accepted in IDLE
        cyc(0, 0, 2'b01, 4'd4, 0, 4'd4, 2'b01, 0, 0, 0, "idle_load");
        cyc(0, 0, 2'b00, 0, 0, 4'd4, 2'b00, 0, 0, 0, "idle_after_load");

        // Asynchronous reset mid-RUN at Q=5, with a request pending
        modulus = 4'd10;
        cyc(1, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 0, 0, "start_async");
        for (int i = 1; i <= 5; i++)
            cyc(0, 0, 2'b00, 0, 0, 4'(i), 2'b00, 1, 0, 0, "to5");
        @(negedge clk);
        #1;
        req = 2'b01; ld0 = 4'd9; rst = 1'b1;
        #1;
        chk("async_rst", {Q, ack, busy, wrap, done}, {4'd0, 2'b00, 1'b0, 1'b0, 1'b0});
        cyc(0, 0, 2'b01, 4'd9, 0, 4'd0, 2'b00, 0, 0, 0, "rst_held_no_ack");
        rst = 1'b0;
        cyc(0, 0, 2'b00, 0, 0, 4'd0, 2'b00, 0, 0, 0, "no_resume");
        cyc(1, 0, 2'b00, 0, 0, 4'd0, 2'b00, 1, 0, 0, "restart_after_rst");
        cyc(0, 0, 2'b00, 0, 0, 4'd1, 2'b00, 1, 0, 0, "count_after_rst");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
